// File: rtl/ffs_arb_pkg.sv
// Shared types and sizing helpers for the round-robin arbiter and its
// find-first-set encoders.
package ffs_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // Index width for an n-entry vector; never narrower than one bit.
    function automatic int unsigned depth(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ffs_rr_arbiter_if.sv
// Request/grant bundle between the arbiter and its requesters/downstream sink.
interface ffs_rr_arbiter_if #(
    parameter int unsigned NUM_REQ = 8
);
    import ffs_arb_pkg::*;

    localparam int unsigned IDX_W = depth(NUM_REQ);

    logic [NUM_REQ-1:0] req;
    logic               gnt_valid;
    logic               gnt_ready;
    logic               gnt_last;
    logic [IDX_W-1:0]   gnt_idx;
    logic [NUM_REQ-1:0] gnt_onehot;
    logic               gnt_timeout;

    modport master (
        input  req,
        input  gnt_ready,
        input  gnt_last,
        output gnt_valid,
        output gnt_idx,
        output gnt_onehot,
        output gnt_timeout
    );

    modport slave (
        output req,
        output gnt_ready,
        output gnt_last,
        input  gnt_valid,
        input  gnt_idx,
        input  gnt_onehot,
        input  gnt_timeout
    );

endinterface

// File: rtl/ffs_m.sv
// Find-first-set encoder: SIDE=1 reports the lowest set bit, SIDE=0 the highest.
// idx_o is forced to zero when no bit is set.
module ffs_m
    import ffs_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter bit          SIDE  = 1'b1,
    localparam int unsigned IDX_W = depth(WIDTH)
) (
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    always_comb begin
        valid_o = |data_i;
        idx_o   = '0;
        if (SIDE) begin
            for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
                if (data_i[i]) begin
                    idx_o = IDX_W'(i);
                end
            end
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (data_i[i]) begin
                    idx_o = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/ffs_rr_arbiter.sv
// Round-robin arbiter: grants one requester at a time and holds the grant across a
// multi-beat transfer until the last beat or the beat limit forces release.
module ffs_rr_arbiter
    import ffs_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 8,
    parameter int unsigned MAX_BEATS = 16
) (
    input logic              clk,
    input logic              rst,
    ffs_rr_arbiter_if.master bus
);

    localparam int unsigned     IDX_W    = depth(NUM_REQ);
    localparam int unsigned     CNT_W    = depth(MAX_BEATS + 1);
    localparam bit              LIMIT_EN = (MAX_BEATS != 0);
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(MAX_BEATS);

    arb_state_e         state_q;
    logic               gnt_valid_q;
    logic [IDX_W-1:0]   gnt_idx_q;
    logic [NUM_REQ-1:0] gnt_onehot_q;
    logic               gnt_timeout_q;
    logic [CNT_W-1:0]   beat_cnt_q;
    logic [CNT_W-1:0]   beat_cnt_d;
    logic [IDX_W-1:0]   last_ptr_q;

    logic [NUM_REQ-1:0] masked_req;
    logic               masked_vld;
    logic               raw_vld;
    logic [IDX_W-1:0]   masked_idx;
    logic [IDX_W-1:0]   raw_idx;
    logic [IDX_W-1:0]   winner;
    logic               beat;
    logic               hit_limit;

    // Only requesters above the previous winner compete in the masked search.
    always_comb begin
        masked_req = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            masked_req[i] = bus.req[i] && (i > int'(last_ptr_q));
        end
    end

    ffs_m #(
        .WIDTH (NUM_REQ),
        .SIDE  (1'b1)
    ) u_ffs_masked (
        .data_i  (masked_req),
        .valid_o (masked_vld),
        .idx_o   (masked_idx)
    );

    ffs_m #(
        .WIDTH (NUM_REQ),
        .SIDE  (1'b1)
    ) u_ffs_raw (
        .data_i  (bus.req),
        .valid_o (raw_vld),
        .idx_o   (raw_idx)
    );

    always_comb begin
        winner     = masked_vld ? masked_idx : raw_idx;
        beat       = gnt_valid_q && bus.gnt_ready;
        // Saturate instead of wrapping when the limit is disabled.
        beat_cnt_d = (&beat_cnt_q) ? beat_cnt_q : beat_cnt_q + 1'b1;
        hit_limit  = LIMIT_EN && (beat_cnt_d == LIMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ARB_IDLE;
            gnt_valid_q   <= 1'b0;
            gnt_idx_q     <= '0;
            gnt_onehot_q  <= '0;
            gnt_timeout_q <= 1'b0;
            beat_cnt_q    <= '0;
            last_ptr_q    <= IDX_W'(NUM_REQ - 1);
        end else begin
            gnt_timeout_q <= 1'b0;
            unique case (state_q)
                ARB_IDLE: begin
                    if (raw_vld) begin
                        state_q      <= ARB_BUSY;
                        gnt_valid_q  <= 1'b1;
                        gnt_idx_q    <= winner;
                        gnt_onehot_q <= NUM_REQ'(1) << winner;
                        last_ptr_q   <= winner;
                        beat_cnt_q   <= '0;
                    end
                end
                ARB_BUSY: begin
                    if (beat) begin
                        if (bus.gnt_last || hit_limit) begin
                            state_q       <= ARB_IDLE;
                            gnt_valid_q   <= 1'b0;
                            gnt_onehot_q  <= '0;
                            beat_cnt_q    <= '0;
                            gnt_timeout_q <= hit_limit && !bus.gnt_last;
                        end else begin
                            beat_cnt_q <= beat_cnt_d;
                        end
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign bus.gnt_valid   = gnt_valid_q;
    assign bus.gnt_idx     = gnt_idx_q;
    assign bus.gnt_onehot  = gnt_onehot_q;
    assign bus.gnt_timeout = gnt_timeout_q;

endmodule
